// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC buffer reader and its skid FIFO.
package fc_pkg;

  localparam int FC_AF_DEFAULT         = 3;
  localparam int FC_DATA_WIDTH_DEFAULT = 8;

  typedef logic [FC_AF_DEFAULT-1:0][FC_DATA_WIDTH_DEFAULT-1:0] fc_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } fc_rd_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fc_reader_skid_fifo.sv
// Two-entry FIFO holding one word per lane plus byte mask and last flags.
// Supports push and pop in the same cycle; outputs read as zero when empty.
module fc_reader_skid_fifo
  import fc_pkg::*;
#(
  parameter int BATCH      = 9,
  parameter int AF         = FC_AF_DEFAULT,
  parameter int WORD_WIDTH = FC_AF_DEFAULT * FC_DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WORD_WIDTH-1:0] in_data [BATCH],
  input  logic [AF-1:0]         in_mask,
  input  logic                  in_last,
  input  logic                  in_job_last,
  output logic [WORD_WIDTH-1:0] out_data [BATCH],
  output logic [AF-1:0]         out_mask,
  output logic                  out_last,
  output logic                  out_job_last,
  output logic [1:0]            count,
  output logic                  full,
  output logic                  empty
);

  logic [AF-1:0] mask_mem [2];
  logic [1:0]    last_mem;
  logic [1:0]    job_last_mem;
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign count   = count_reg;
  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= !wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= !rd_ptr_reg;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload is not reset; it is only observed through the empty gate.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mask_mem[wr_ptr_reg]     <= in_mask;
      last_mem[wr_ptr_reg]     <= in_last;
      job_last_mem[wr_ptr_reg] <= in_job_last;
    end
  end

  for (genvar gi = 0; gi < BATCH; gi++) begin : g_lane
    logic [WORD_WIDTH-1:0] lane_mem [2];

    always_ff @(posedge clk) begin
      if (push_ok) lane_mem[wr_ptr_reg] <= in_data[gi];
    end

    assign out_data[gi] = empty ? '0 : lane_mem[rd_ptr_reg];
  end

  assign out_mask     = empty ? '0   : mask_mem[rd_ptr_reg];
  assign out_last     = empty ? 1'b0 : last_mem[rd_ptr_reg];
  assign out_job_last = empty ? 1'b0 : job_last_mem[rd_ptr_reg];

endmodule

// File: rtl/fc_buffer_reader.sv
// Replays the FC activation vector from the BATCH buffer RAMs to the PE array,
// FC_PASSES times, with tail-byte masking and per-pass / per-job last flags.
module fc_buffer_reader
  import fc_pkg::*;
#(
  parameter int AF         = FC_AF_DEFAULT,
  parameter int BATCH      = 9,
  parameter int DATA_WIDTH = FC_DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = 32,
  parameter int FC_IN_LEN  = 4608,
  parameter int FC_PASSES  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH-1:0]      RAM_reader_rd_ADDR [BATCH],
  input  logic [AF*DATA_WIDTH-1:0]   RAM_reader_rd_data [BATCH],
  output logic [AF*DATA_WIDTH-1:0]   fc_data_out [BATCH],
  output logic [AF-1:0]              fc_byte_valid,
  output logic                       fc_data_valid,
  input  logic                       fc_data_ready,
  output logic                       fc_data_last,
  output logic                       fc_job_last
);

  localparam int WORD_WIDTH = AF * DATA_WIDTH;
  localparam int FC_WORDS   = ceil_div(FC_IN_LEN, AF);
  localparam int WC_W       = (FC_WORDS > 1) ? $clog2(FC_WORDS) : 1;
  localparam int PC_W       = $clog2(FC_PASSES + 1);
  localparam int TAIL_BYTES = FC_IN_LEN - (FC_WORDS - 1) * AF;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(FC_WORDS - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(FC_PASSES - 1);

  fc_rd_state_e          state_reg;
  logic [WC_W-1:0]       wc_reg;
  logic [PC_W-1:0]       pc_reg;
  logic [ADDR_WIDTH-1:0] addr_hold_reg;
  logic [ADDR_WIDTH-1:0] addr_now;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic                  inflight_job_last_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic [1:0]            fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  issue;
  logic                  slot_free;
  logic                  word_last;
  logic                  word_job_last;
  logic [AF-1:0]         tail_mask;
  logic [AF-1:0]         push_mask;
  logic [WORD_WIDTH-1:0] push_data [BATCH];
  logic                  out_job_last;

  assign pop = !fifo_empty && fc_data_ready;

  // FIFO entries plus the outstanding read never exceed two; a word leaving
  // this cycle frees its slot immediately so the stream runs at one word/cycle.
  assign slot_free = (({1'b0, fifo_count} + {2'b00, inflight_reg}) < 3'd2);
  assign issue     = (state_reg == READ) && (!fifo_full || pop) && (slot_free || pop);

  assign word_last     = (wc_reg == WC_LAST);
  assign word_job_last = word_last && (pc_reg == PC_LAST);

  assign addr_now = issue ? ADDR_WIDTH'(wc_reg) : addr_hold_reg;

  for (genvar gi = 0; gi < BATCH; gi++) begin : g_addr
    assign RAM_reader_rd_ADDR[gi] = addr_now;
  end

  for (genvar gi = 0; gi < AF; gi++) begin : g_tail
    assign tail_mask[gi] = (gi < TAIL_BYTES);
  end

  assign push_mask = inflight_last_reg ? tail_mask : '1;

  always_comb begin
    for (int l = 0; l < BATCH; l++) begin
      push_data[l] = '0;
      for (int b = 0; b < AF; b++) begin
        if (push_mask[b]) begin
          push_data[l][b*DATA_WIDTH +: DATA_WIDTH] = RAM_reader_rd_data[l][b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg             <= IDLE;
      wc_reg                <= '0;
      pc_reg                <= '0;
      addr_hold_reg         <= '0;
      inflight_reg          <= 1'b0;
      inflight_last_reg     <= 1'b0;
      inflight_job_last_reg <= 1'b0;
      busy_reg              <= 1'b0;
      done_reg              <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= issue;
      if (issue) begin
        addr_hold_reg         <= addr_now;
        inflight_last_reg     <= word_last;
        inflight_job_last_reg <= word_job_last;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= READ;
            wc_reg    <= '0;
            pc_reg    <= '0;
            busy_reg  <= 1'b1;
          end
        end
        READ: begin
          if (issue) begin
            if (!word_last) begin
              wc_reg <= wc_reg + 1'b1;
            end else begin
              wc_reg <= '0;
              if (pc_reg != PC_LAST) pc_reg <= pc_reg + 1'b1;
              else                   state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The job-last word is the final one, so its handshake empties the pipe.
          if (pop && out_job_last) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  fc_reader_skid_fifo #(
    .BATCH      (BATCH),
    .AF         (AF),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (inflight_reg),
    .pop          (pop),
    .in_data      (push_data),
    .in_mask      (push_mask),
    .in_last      (inflight_last_reg),
    .in_job_last  (inflight_job_last_reg),
    .out_data     (fc_data_out),
    .out_mask     (fc_byte_valid),
    .out_last     (fc_data_last),
    .out_job_last (out_job_last),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  assign fc_job_last   = out_job_last;
  assign fc_data_valid = !fifo_empty;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_fc_buffer_reader.sv
// Scoreboard bench for fc_buffer_reader: a short-vector instance with a padded
// tail and an exact-multiple instance, each fed by a registered RAM model.
module tb_fc_buffer_reader;
  import fc_pkg::*;

  typedef struct {
    int   addr;
    logic last;
    logic job_last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        busy, done, valid, last, job_last;
  logic [2:0]  byte_valid;
  logic [31:0] ram_addr [9];
  logic [23:0] ram_rd_data [9];
  logic [23:0] fc_out [9];
  logic [215:0] data_flat;

  logic        start9 = 1'b0;
  logic        ready9 = 1'b1;
  logic        busy9, done9, valid9, last9, job_last9;
  logic [2:0]  byte_valid9;
  logic [31:0] ram9_addr [9];
  logic [23:0] ram9_rd_data [9];
  logic [23:0] fc9_out [9];
  logic [215:0] data9_flat;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int xfer_cnt = 0;
  logic mon_en = 1'b0;
  logic pend_done = 1'b0;
  logic prev_stall = 1'b0;
  logic [215:0] prev_data;
  logic [4:0] prev_flags;
  exp_t sb[$];
  exp_t mon_e;

  fc_buffer_reader #(.AF(3), .BATCH(9), .DATA_WIDTH(8), .ADDR_WIDTH(32),
                     .FC_IN_LEN(8), .FC_PASSES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .RAM_reader_rd_ADDR(ram_addr), .RAM_reader_rd_data(ram_rd_data),
    .fc_data_out(fc_out), .fc_byte_valid(byte_valid), .fc_data_valid(valid),
    .fc_data_ready(ready), .fc_data_last(last), .fc_job_last(job_last)
  );

  fc_buffer_reader #(.AF(3), .BATCH(9), .DATA_WIDTH(8), .ADDR_WIDTH(32),
                     .FC_IN_LEN(9), .FC_PASSES(1)) u_dut9 (
    .clk(clk), .rst(rst), .start(start9), .busy(busy9), .done(done9),
    .RAM_reader_rd_ADDR(ram9_addr), .RAM_reader_rd_data(ram9_rd_data),
    .fc_data_out(fc9_out), .fc_byte_valid(byte_valid9), .fc_data_valid(valid9),
    .fc_data_ready(ready9), .fc_data_last(last9), .fc_job_last(job_last9)
  );

  for (genvar gi = 0; gi < 9; gi++) begin : g_flat
    assign data_flat[gi*24 +: 24]  = fc_out[gi];
    assign data9_flat[gi*24 +: 24] = fc9_out[gi];
  end

  // Lane k, address a holds bytes {k, a, 0xA0+k}; byte 2 is nonzero so tail zeroing shows.
  function automatic fc_word_t ram_word(input int k, input logic [31:0] a);
    fc_word_t w;
    w[0] = 8'(k);
    w[1] = a[7:0];
    w[2] = 8'(8'hA0 + k);
    return w;
  endfunction

  function automatic logic [215:0] exp_flat(input int addr, input logic tail);
    logic [215:0] v;
    fc_word_t w;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      w = ram_word(k, 32'(addr));
      if (tail) w[2] = 8'h00;
      v[k*24 +: 24] = w;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 9; k++) begin
      ram_rd_data[k]  <= ram_word(k, ram_addr[k]);
      ram9_rd_data[k] <= ram_word(k, ram9_addr[k]);
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      ready = 1'b1;
      else if (ready_mode == 2) ready = 1'b0;
      else                      ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_done || done) check_eq("done_pulse", 256'(done), 256'(pend_done));
      pend_done = 1'b0;
      if (prev_stall) begin
        check_eq("hold_valid", 256'(valid), 256'(1));
        check_eq("hold_data", 256'(data_flat), 256'(prev_data));
        check_eq("hold_flags", 256'({byte_valid, last, job_last}), 256'(prev_flags));
      end
      if (valid && ready) begin
        if (sb.size() == 0) begin
          check_eq("extra_word", 256'(1), 256'(0));
        end else begin
          mon_e = sb.pop_front();
          check_eq("word_data", 256'(data_flat), 256'(exp_flat(mon_e.addr, mon_e.last)));
          check_eq("byte_valid", 256'(byte_valid), 256'(mon_e.last ? 3'b011 : 3'b111));
          check_eq("data_last", 256'(last), 256'(mon_e.last));
          check_eq("job_last", 256'(job_last), 256'(mon_e.job_last));
          if (mon_e.job_last) pend_done = 1'b1;
        end
        $display("xfer %0d addr_exp=%0d last=%0b job_last=%0b mask=%b", xfer_cnt, mon_e.addr, last, job_last, byte_valid);
        xfer_cnt++;
      end
      prev_stall = valid && !ready;
      prev_data  = data_flat;
      prev_flags = {byte_valid, last, job_last};
    end
  end

  task automatic push_job();
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 3; w++) begin
        sb.push_back('{addr: w, last: (w == 2), job_last: (w == 2 && p == 1)});
      end
    end
  endtask

  task automatic start_job();
    @(posedge clk); #1;
    start = 1'b1;
    push_job();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_latency(input string tag);
    @(negedge clk); check_eq({tag, "_lat1"}, 256'(valid), 256'(0));
    check_eq({tag, "_busy"}, 256'(busy), 256'(1));
    @(negedge clk); check_eq({tag, "_lat2"}, 256'(valid), 256'(0));
    @(negedge clk); check_eq({tag, "_lat3"}, 256'(valid), 256'(1));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_complete"}, 256'(n < budget), 256'(1));
    repeat (3) @(negedge clk);
    check_eq({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 256'(valid), 256'(0));
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_done", 256'(done), 256'(0));
    check_eq("rst_addr", 256'(ram_addr[0]), 256'(0));
    check_eq("rst_out", 256'({data_flat, byte_valid, last, job_last}), 256'(0));
    mon_en = 1'b1;

    // basic stream
    start_job();
    check_latency("basic");
    wait_idle("basic", 200);

    // random backpressure
    ready_mode = 1;
    start_job();
    wait_idle("bp", 400);
    ready_mode = 0;

    // start while busy is ignored; start during done launches a new job
    start_job();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_start_done_seen", 256'(done), 256'(1));
    start = 1'b1;
    push_job();
    @(posedge clk); #1 start = 1'b0;
    check_latency("done_start");
    wait_idle("done_start", 200);

    // reset mid-job after three transfers
    base = xfer_cnt;
    start_job();
    n = 0;
    while (xfer_cnt < base + 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_eq("rst_mid_xfers", 256'(xfer_cnt >= base + 3), 256'(1));
    mon_en = 1'b0;
    sb.delete();
    pend_done = 1'b0;
    prev_stall = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_valid", 256'(valid), 256'(0));
    check_eq("rst_mid_busy", 256'(busy), 256'(0));
    check_eq("rst_mid_done", 256'(done), 256'(0));
    mon_en = 1'b1;
    start_job();
    check_latency("restart");
    wait_idle("restart", 200);

    // ready held low at job start
    ready_mode = 2;
    start_job();
    repeat (20) @(negedge clk);
    check_eq("stall_valid", 256'(valid), 256'(1));
    check_eq("stall_addr", 256'(ram_addr[0]), 256'(1));
    check_eq("stall_addr_lane8", 256'(ram_addr[8]), 256'(1));
    check_eq("stall_word0", 256'(data_flat), 256'(exp_flat(0, 1'b0)));
    ready_mode = 0;
    wait_idle("stall", 200);

    // exact multiple: three full words, back to back
    @(posedge clk); #1 start9 = 1'b1;
    @(posedge clk); #1 start9 = 1'b0;
    n = 0;
    while (!valid9 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("u9_valid", 256'(valid9), 256'(1));
    for (int w = 0; w < 3; w++) begin
      check_eq("u9_data", 256'(data9_flat), 256'(exp_flat(w, 1'b0)));
      check_eq("u9_mask", 256'(byte_valid9), 256'(3'b111));
      check_eq("u9_last", 256'(last9), 256'(w == 2));
      check_eq("u9_job_last", 256'(job_last9), 256'(w == 2));
      $display("u9 word %0d mask=%b last=%0b", w, byte_valid9, last9);
      @(negedge clk);
    end
    check_eq("u9_done", 256'(done9), 256'(1));
    check_eq("u9_busy", 256'(busy9), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
